// File: rtl/run_detector.sv
// Run-length detector: tracks the current run of identical bits with a 3-state FSM plus a
// saturating counter, and flags runs of RUN_LEN or more with a Mealy output and hit counter.
`timescale 1ns/1ps
module run_detector #(
  parameter int unsigned RUN_LEN = 4,
  parameter int unsigned CNT_W   = $clog2(RUN_LEN + 1),
  parameter int unsigned HIT_W   = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic             w,
  input  logic [1:0]       mode,
  input  logic             clr,
  output logic             z,
  output logic             z_q,
  output logic             run_bit,
  output logic [CNT_W-1:0] run_cnt,
  output logic [HIT_W-1:0] hit_cnt
);

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun0 = 2'd1,
    StRun1 = 2'd2
  } state_e;

  localparam logic [CNT_W-1:0] RunLenC = CNT_W'(RUN_LEN);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, next_cnt;
  logic [HIT_W-1:0] hit_q, hit_d;
  logic             z_d;
  logic             same_run, run_sat, allow;

  always_comb begin
    same_run = ((state_q == StRun0) && !w) || ((state_q == StRun1) && w);
    run_sat  = same_run && (cnt_q == RunLenC);
    next_cnt = same_run ? (run_sat ? cnt_q : cnt_q + CNT_W'(1)) : CNT_W'(1);

    unique case (mode)
      2'b00:   allow = 1'b1;
      2'b01:   allow = !w;
      2'b10:   allow = w;
      default: allow = 1'b0;
    endcase

    // Gated by rst_n so z stays low while reset is held, even when RUN_LEN is 1.
    z   = rst_n && in_valid && !clr && allow && (next_cnt >= RunLenC);
    z_d = z;

    state_d = state_q;
    cnt_d   = cnt_q;
    hit_d   = hit_q;
    if (clr) begin
      state_d = StIdle;
      cnt_d   = '0;
      hit_d   = '0;
    end else if (in_valid) begin
      state_d = w ? StRun1 : StRun0;
      cnt_d   = next_cnt;
      // A run already at RUN_LEN was counted when it got there (or predates the mode enable).
      if (z && !run_sat && (hit_q != {HIT_W{1'b1}})) begin
        hit_d = hit_q + HIT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      hit_q   <= '0;
      z_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hit_q   <= hit_d;
      z_q     <= z_d;
    end
  end

  assign run_bit = (state_q == StRun1);
  assign run_cnt = cnt_q;
  assign hit_cnt = hit_q;

endmodule

// File: tb/tb_run_detector.sv
// Directed bench for run_detector: main instance (RUN_LEN=4), a HIT_W=2 instance for hit
// saturation and a RUN_LEN=1 instance, all sharing the same input stream.
`timescale 1ns/1ps
module tb_run_detector;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic       w = 1'b0;
  logic       clr = 1'b0;
  logic [1:0] mode = 2'b00;

  logic       z, z_q, run_bit;
  logic [2:0] run_cnt;
  logic [7:0] hit_cnt;
  logic       s_z, s_zq, s_bit;
  logic [2:0] s_cnt;
  logic [1:0] s_hit;
  logic       o_z, o_zq, o_bit;
  logic [0:0] o_cnt;
  logic [7:0] o_hit;

  int errors = 0;
  int checks = 0;

  run_detector #(.RUN_LEN(4), .HIT_W(8)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .w(w), .mode(mode), .clr(clr),
    .z(z), .z_q(z_q), .run_bit(run_bit), .run_cnt(run_cnt), .hit_cnt(hit_cnt)
  );

  run_detector #(.RUN_LEN(4), .HIT_W(2)) u_sat (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .w(w), .mode(mode), .clr(clr),
    .z(s_z), .z_q(s_zq), .run_bit(s_bit), .run_cnt(s_cnt), .hit_cnt(s_hit)
  );

  run_detector #(.RUN_LEN(1), .HIT_W(8)) u_one (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .w(w), .mode(mode), .clr(clr),
    .z(o_z), .z_q(o_zq), .run_bit(o_bit), .run_cnt(o_cnt), .hit_cnt(o_hit)
  );

  always #5 clk = ~clk;

  // Drive one cycle of inputs at negedge, capture the Mealy outputs mid-cycle, then step past
  // the rising edge so registered outputs can be read.
  task automatic sample(input logic v, input logic b, input logic c,
                        output logic zs, output logic zo);
    @(negedge clk);
    in_valid = v; w = b; clr = c;
    #1;
    zs = z; zo = o_z;
    @(posedge clk);
    #1;
    in_valid = 1'b0; clr = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; in_valid = 1'b0; clr = 1'b0; w = 1'b0; mode = 2'b00;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b1; w = 1'b0; mode = 2'b00;
    #12;
    checks++; if (z !== 1'b0) begin errors++; $display("FAIL reset_z: got %0d expected 0", z); end
    checks++; if (o_z !== 1'b0) begin errors++; $display("FAIL reset_z_len1: got %0d expected 0", o_z); end
    checks++; if (z_q !== 1'b0) begin errors++; $display("FAIL reset_zq: got %0d expected 0", z_q); end
    checks++; if (run_cnt !== 3'd0) begin errors++; $display("FAIL reset_cnt: got %0d expected 0", run_cnt); end
    checks++; if (run_bit !== 1'b0) begin errors++; $display("FAIL reset_bit: got %0d expected 0", run_bit); end
    checks++; if (hit_cnt !== 8'd0) begin errors++; $display("FAIL reset_hit: got %0d expected 0", hit_cnt); end
    in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    logic sv[6] = '{0, 0, 0, 0, 0, 1};
    logic ez[6] = '{0, 0, 0, 1, 1, 0};
    int   ec[6] = '{1, 2, 3, 4, 4, 1};
    logic zs, zo;
    do_reset();
    for (int i = 0; i < 6; i++) begin
      sample(1'b1, sv[i], 1'b0, zs, zo);
      checks++; if (zs !== ez[i]) begin errors++; $display("FAIL basic_z[%0d]: got %0d expected %0d", i, zs, ez[i]); end
      checks++; if (run_cnt !== ec[i]) begin errors++; $display("FAIL basic_cnt[%0d]: got %0d expected %0d", i, run_cnt, ec[i]); end
      checks++; if (z_q !== ez[i]) begin errors++; $display("FAIL basic_zq[%0d]: got %0d expected %0d", i, z_q, ez[i]); end
    end
    checks++; if (hit_cnt !== 8'd1) begin errors++; $display("FAIL basic_hit: got %0d expected 1", hit_cnt); end
    checks++; if (run_bit !== 1'b1) begin errors++; $display("FAIL basic_bit: got %0d expected 1", run_bit); end
  endtask

  task automatic test_ones_mode();
    logic sa[8] = '{1, 1, 1, 0, 1, 1, 1, 1};
    logic sb[8] = '{0, 0, 0, 0, 1, 1, 1, 1};
    logic zs, zo;
    do_reset();
    mode = 2'b10;
    for (int i = 0; i < 8; i++) begin
      sample(1'b1, sa[i], 1'b0, zs, zo);
      checks++; if (zs !== (i == 7)) begin errors++; $display("FAIL ones_a_z[%0d]: got %0d expected %0d", i, zs, i == 7); end
    end
    checks++; if (hit_cnt !== 8'd1) begin errors++; $display("FAIL ones_a_hit: got %0d expected 1", hit_cnt); end
    sample(1'b0, 1'b0, 1'b1, zs, zo);
    checks++; if (hit_cnt !== 8'd0) begin errors++; $display("FAIL ones_clr_hit: got %0d expected 0", hit_cnt); end
    for (int i = 0; i < 8; i++) begin
      sample(1'b1, sb[i], 1'b0, zs, zo);
      checks++; if (zs !== (i == 7)) begin errors++; $display("FAIL ones_b_z[%0d]: got %0d expected %0d", i, zs, i == 7); end
    end
    checks++; if (hit_cnt !== 8'd1) begin errors++; $display("FAIL ones_b_hit: got %0d expected 1", hit_cnt); end
  endtask

  task automatic test_gaps();
    logic vv[7] = '{1, 1, 0, 0, 0, 1, 1};
    logic ez[7] = '{0, 0, 0, 0, 0, 0, 1};
    int   ec[7] = '{1, 2, 2, 2, 2, 3, 4};
    logic zs, zo;
    do_reset();
    for (int i = 0; i < 7; i++) begin
      sample(vv[i], 1'b1, 1'b0, zs, zo);
      checks++; if (zs !== ez[i]) begin errors++; $display("FAIL gaps_z[%0d]: got %0d expected %0d", i, zs, ez[i]); end
      checks++; if (run_cnt !== ec[i]) begin errors++; $display("FAIL gaps_cnt[%0d]: got %0d expected %0d", i, run_cnt, ec[i]); end
    end
    checks++; if (hit_cnt !== 8'd1) begin errors++; $display("FAIL gaps_hit: got %0d expected 1", hit_cnt); end
  endtask

  task automatic test_clr();
    logic zs, zo;
    do_reset();
    for (int i = 0; i < 4; i++) sample(1'b1, 1'b1, 1'b0, zs, zo);
    checks++; if (hit_cnt !== 8'd1) begin errors++; $display("FAIL clr_pre_hit: got %0d expected 1", hit_cnt); end
    for (int i = 0; i < 3; i++) sample(1'b1, 1'b0, 1'b0, zs, zo);
    checks++; if (run_cnt !== 3'd3) begin errors++; $display("FAIL clr_pre_cnt: got %0d expected 3", run_cnt); end
    // Without clr this would be the 4th zero and fire z.
    sample(1'b1, 1'b0, 1'b1, zs, zo);
    checks++; if (zs !== 1'b0) begin errors++; $display("FAIL clr_z: got %0d expected 0", zs); end
    checks++; if (zo !== 1'b0) begin errors++; $display("FAIL clr_z_len1: got %0d expected 0", zo); end
    checks++; if (run_cnt !== 3'd0) begin errors++; $display("FAIL clr_cnt: got %0d expected 0", run_cnt); end
    checks++; if (hit_cnt !== 8'd0) begin errors++; $display("FAIL clr_hit: got %0d expected 0", hit_cnt); end
    checks++; if (z_q !== 1'b0) begin errors++; $display("FAIL clr_zq: got %0d expected 0", z_q); end
    for (int i = 0; i < 4; i++) begin
      sample(1'b1, 1'b0, 1'b0, zs, zo);
      checks++; if (zs !== (i == 3)) begin errors++; $display("FAIL clr_post_z[%0d]: got %0d expected %0d", i, zs, i == 3); end
      checks++; if (run_cnt !== i + 1) begin errors++; $display("FAIL clr_post_cnt[%0d]: got %0d expected %0d", i, run_cnt, i + 1); end
    end
    checks++; if (hit_cnt !== 8'd1) begin errors++; $display("FAIL clr_post_hit: got %0d expected 1", hit_cnt); end
  endtask

  task automatic test_saturation();
    logic zs, zo;
    int   es[5] = '{1, 2, 3, 3, 3};
    do_reset();
    for (int r = 0; r < 5; r++) begin
      for (int k = 0; k < 4; k++) sample(1'b1, r[0], 1'b0, zs, zo);
      checks++; if (s_hit !== es[r]) begin errors++; $display("FAIL sat_hit[%0d]: got %0d expected %0d", r, s_hit, es[r]); end
    end
    checks++; if (hit_cnt !== 8'd5) begin errors++; $display("FAIL sat_main_hit: got %0d expected 5", hit_cnt); end
  endtask

  task automatic test_run_len1();
    logic sv[4] = '{0, 0, 1, 0};
    logic zs, zo;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      sample(1'b1, sv[i], 1'b0, zs, zo);
      checks++; if (zo !== 1'b1) begin errors++; $display("FAIL len1_z[%0d]: got %0d expected 1", i, zo); end
    end
    checks++; if (o_hit !== 8'd3) begin errors++; $display("FAIL len1_hit: got %0d expected 3", o_hit); end
    checks++; if (o_cnt !== 1'b1) begin errors++; $display("FAIL len1_cnt: got %0d expected 1", o_cnt); end
    mode = 2'b01;
    sample(1'b1, 1'b1, 1'b0, zs, zo);
    checks++; if (zo !== 1'b0) begin errors++; $display("FAIL len1_mode_z: got %0d expected 0", zo); end
    sample(1'b1, 1'b0, 1'b0, zs, zo);
    checks++; if (zo !== 1'b1) begin errors++; $display("FAIL len1_zero_z: got %0d expected 1", zo); end
    checks++; if (o_hit !== 8'd4) begin errors++; $display("FAIL len1_zero_hit: got %0d expected 4", o_hit); end
  endtask

  task automatic test_async_reset();
    logic zs, zo;
    do_reset();
    for (int i = 0; i < 5; i++) sample(1'b1, 1'b0, 1'b0, zs, zo);
    checks++; if (z_q !== 1'b1) begin errors++; $display("FAIL arst_pre_zq: got %0d expected 1", z_q); end
    @(negedge clk);
    in_valid = 1'b1; w = 1'b0;
    #1;
    checks++; if (z !== 1'b1) begin errors++; $display("FAIL arst_pre_z: got %0d expected 1", z); end
    #1 rst_n = 1'b0;
    #1;
    checks++; if (z !== 1'b0) begin errors++; $display("FAIL arst_z: got %0d expected 0", z); end
    checks++; if (z_q !== 1'b0) begin errors++; $display("FAIL arst_zq: got %0d expected 0", z_q); end
    checks++; if (run_cnt !== 3'd0) begin errors++; $display("FAIL arst_cnt: got %0d expected 0", run_cnt); end
    checks++; if (hit_cnt !== 8'd0) begin errors++; $display("FAIL arst_hit: got %0d expected 0", hit_cnt); end
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    checks++; if (run_cnt !== 3'd1) begin errors++; $display("FAIL arst_restart_cnt: got %0d expected 1", run_cnt); end
  endtask

  task automatic test_mode_switch();
    logic zs, zo;
    do_reset();
    mode = 2'b11;
    for (int i = 0; i < 8; i++) begin
      sample(1'b1, 1'b0, 1'b0, zs, zo);
      checks++; if (zs !== 1'b0) begin errors++; $display("FAIL off_z[%0d]: got %0d expected 0", i, zs); end
    end
    checks++; if (hit_cnt !== 8'd0) begin errors++; $display("FAIL off_hit: got %0d expected 0", hit_cnt); end
    checks++; if (run_cnt !== 3'd4) begin errors++; $display("FAIL off_cnt: got %0d expected 4", run_cnt); end
    mode = 2'b01;
    sample(1'b1, 1'b0, 1'b0, zs, zo);
    checks++; if (zs !== 1'b1) begin errors++; $display("FAIL switch_z: got %0d expected 1", zs); end
    checks++; if (hit_cnt !== 8'd0) begin errors++; $display("FAIL switch_hit: got %0d expected 0", hit_cnt); end
    checks++; if (z_q !== 1'b1) begin errors++; $display("FAIL switch_zq: got %0d expected 1", z_q); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_ones_mode();
    test_gaps();
    test_clr();
    test_saturation();
    test_run_len1();
    test_async_reset();
    test_mode_switch();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
